ggc_loader: RTL and testbench

Front end of the cheat-code path. Accepts NES Game Genie codes as a stream of 4-bit letter values and decodes each 6- or 8-letter code into address, compare and replace bytes. Writes the result into the next free cheat slot through the slot-register write port, the same `{slot, byte}` addressing the cheat comparator consumes. Also clears all slots on reset exit and on command.

---
 rtl/ggc_loader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ggc_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ggc_loader.sv
// ---------------------------------------------------------------------------
// ggc_loader
// Decodes NES Game Genie codes (6 or 8 letters, 4-bit letter values) into
// address / compare / replace bytes and writes them into the next free cheat
// slot through a {slot, byte} addressed register write port. All slots are
// disabled automatically after reset and on a clr pulse.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_nib/in_last/
//   in_valid/in_ready : letter stream (valid/ready handshake)
//   clr               : single-cycle request to disable every slot
//   wr_we/wr_addr/
//   wr_data           : slot register write port, addr = {slot[5:0], byte[1:0]}
//   busy              : high while writing a slot or clearing
//   slots_used/full   : number of loaded slots, all slots loaded
//   err/err_code      : one-cycle error pulse, 1 = bad length, 2 = slots full
// ---------------------------------------------------------------------------
module ggc_loader #(
  parameter int unsigned SLOTS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_nib,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clr,
  output logic       wr_we,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic [6:0] slots_used,
  output logic       full,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned MAX_LET = 8;
  localparam logic [1:0]  ERR_LEN  = 2'd1;
  localparam logic [1:0]  ERR_FULL = 2'd2;

  // Byte offsets inside a slot
  localparam logic [1:0] B_ADDR_LO = 2'd0;
  localparam logic [1:0] B_ENABLE  = 2'd1;
  localparam logic [1:0] B_CMP     = 2'd2;
  localparam logic [1:0] B_REP     = 2'd3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_CLEAR   = 2'd2
  } state_t;

  state_t           r_state;
  logic [NIB_W-1:0] r_nib [MAX_LET];
  logic [3:0]       r_count;
  logic             r_ovf;
  logic [1:0]       r_phase;
  logic             r_clr_pend;
  logic             r_clr_arm;
  logic [5:0]       r_cidx;
  logic [7:0]       r_b1;
  logic [7:0]       r_b2;
  logic [7:0]       r_b3;

  logic             r_in_ready;
  logic             r_wr_we;
  logic [7:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_busy;
  logic [6:0]       r_slots_used;
  logic             r_full;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_accept;
  logic [NIB_W-1:0] w_nib [MAX_LET];
  logic             w_long;
  logic             w_len_ok;
  logic [14:0]      w_addr;
  logic [7:0]       w_rep;
  logic [7:0]       w_cmp;
  logic [5:0]       w_slot;

  assign w_accept = in_valid & r_in_ready;
  assign w_slot   = r_slots_used[5:0];

  // Letter view with the letter being accepted this cycle already in place,
  // so the final letter can be decoded on the same edge that accepts it.
  always_comb begin
    for (int i = 0; i < MAX_LET; i++) begin
      w_nib[i] = (w_accept && (r_count == 4'(i))) ? in_nib : r_nib[i];
    end
  end

  // Total length is r_count + 1 when the last letter arrives.
  assign w_long   = (r_count == 4'd7);
  assign w_len_ok = !r_ovf && ((r_count == 4'd5) || (r_count == 4'd7));

  // Game Genie bit scramble
  always_comb begin
    w_addr = {w_nib[3][2:0], w_nib[4][3], w_nib[5][2:0], w_nib[1][3],
              w_nib[2][2:0], w_nib[3][3], w_nib[4][2:0]};
    w_rep  = {w_nib[0][3], w_nib[1][2:0],
              (w_long ? w_nib[7][3] : w_nib[5][3]), w_nib[0][2:0]};
    // Six-letter codes use compare == replace, which disables the compare
    w_cmp  = w_long ? {w_nib[6][3], w_nib[7][2:0], w_nib[5][3], w_nib[6][2:0]}
                    : w_rep;
  end

  // Control FSM; every output is registered one cycle ahead of its use
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      for (int i = 0; i < MAX_LET; i++) r_nib[i] <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_phase      <= '0;
      r_clr_pend   <= 1'b0;
      r_clr_arm    <= 1'b1;
      r_cidx       <= '0;
      r_b1         <= '0;
      r_b2         <= '0;
      r_b3         <= '0;
      r_in_ready   <= 1'b0;
      r_wr_we      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_slots_used <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_err      <= 1'b0;
      r_err_code <= '0;

      case (r_state)
        ST_COLLECT: begin
          if (clr) begin
            // Drop any partial code and start clearing from slot 0
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_state    <= ST_CLEAR;
            r_cidx     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_we    <= 1'b1;
            r_wr_addr  <= {6'd0, B_ENABLE};
            r_wr_data  <= 8'h00;
          end else if (w_accept) begin
            if (in_last) begin
              r_count <= '0;
              r_ovf   <= 1'b0;
              if (!w_len_ok) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_LEN;
              end else if (r_full) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_FULL;
              end else begin
                r_state    <= ST_WRITE;
                r_phase    <= 2'd0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
                r_wr_we    <= 1'b1;
                r_wr_addr  <= {w_slot, B_ADDR_LO};
                r_wr_data  <= w_addr[7:0];
                r_b1       <= {1'b1, w_addr[14:8]};
                r_b2       <= w_cmp;
                r_b3       <= w_rep;
              end
            end else if (r_count < 4'(MAX_LET)) begin
              r_nib[r_count[2:0]] <= in_nib;
              r_count             <= r_count + 4'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (clr) r_clr_pend <= 1'b1;
          case (r_phase)
            2'd0: begin
              r_wr_addr <= {w_slot, B_CMP};
              r_wr_data <= r_b2;
              r_phase   <= 2'd1;
            end
            2'd1: begin
              r_wr_addr <= {w_slot, B_REP};
              r_wr_data <= r_b3;
              r_phase   <= 2'd2;
            end
            2'd2: begin
              // Enable byte last so the slot arms with all bytes valid
              r_wr_addr <= {w_slot, B_ENABLE};
              r_wr_data <= r_b1;
              r_phase   <= 2'd3;
            end
            default: begin
              r_slots_used <= r_slots_used + 7'd1;
              r_full       <= ((r_slots_used + 7'd1) == 7'(SLOTS));
              r_phase      <= 2'd0;
              r_clr_pend   <= 1'b0;
              if (r_clr_pend || clr) begin
                r_state   <= ST_CLEAR;
                r_cidx    <= '0;
                r_wr_we   <= 1'b1;
                r_wr_addr <= {6'd0, B_ENABLE};
                r_wr_data <= 8'h00;
              end else begin
                r_state    <= ST_COLLECT;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b0;
                r_wr_we    <= 1'b0;
                r_wr_addr  <= '0;
                r_wr_data  <= '0;
              end
            end
          endcase
        end

        ST_CLEAR: begin
          if (r_clr_arm) begin
            // First cycle after reset: nothing presented yet
            r_clr_arm <= 1'b0;
            r_cidx    <= '0;
            r_busy    <= 1'b1;
            r_wr_we   <= 1'b1;
            r_wr_addr <= {6'd0, B_ENABLE};
            r_wr_data <= 8'h00;
          end else if (r_cidx == 6'(SLOTS - 1)) begin
            r_slots_used <= '0;
            r_full       <= 1'b0;
            r_state      <= ST_COLLECT;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_wr_we      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
          end else begin
            r_cidx    <= r_cidx + 6'd1;
            r_wr_addr <= {6'(r_cidx + 6'd1), B_ENABLE};
            r_wr_data <= 8'h00;
          end
        end

        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign wr_we      = r_wr_we;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign slots_used = r_slots_used;
  assign full       = r_full;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_ggc_loader.sv
// Scoreboard bench for ggc_loader: expected writes and error pulses are
// queued by the stimulus; a monitor pops and compares on every strobe.
module tb_ggc_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_nib;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic       wr_we;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [6:0] slots_used;
  logic       full;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [1:0] exp_err[$];

  ggc_loader #(.SLOTS(8)) dut (
    .clk(clk), .rst(rst), .in_nib(in_nib), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .clr(clr), .wr_we(wr_we),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .slots_used(slots_used), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write strobe and error pulse against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", {24'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
          check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
        end
      end
      if (err) begin
        if (exp_err.size() == 0) begin
          check("unexpected_err_code", {30'd0, err_code}, 32'hFFFF_FFFF);
        end else begin
          logic [1:0] ec;
          ec = exp_err.pop_front();
          check("err_code", {30'd0, err_code}, {30'd0, ec});
        end
      end
    end
  end

  task automatic push_clear();
    for (int s = 0; s < 8; s++) exp_wr.push_back({6'(s), 2'd1, 8'h00});
  endtask

  task automatic push_slot(input int slot, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3);
    exp_wr.push_back({6'(slot), 2'd0, b0});
    exp_wr.push_back({6'(slot), 2'd2, b2});
    exp_wr.push_back({6'(slot), 2'd3, b3});
    exp_wr.push_back({6'(slot), 2'd1, b1});
  endtask

  // Drive one letter and hold it until accepted at a rising edge
  task automatic send_letter(input logic [3:0] nib, input logic last);
    int wait_c;
    @(negedge clk);
    in_valid = 1'b1;
    in_nib   = nib;
    in_last  = last;
    wait_c   = 0;
    while (!in_ready && wait_c < 100) begin
      @(negedge clk);
      wait_c++;
    end
    if (wait_c >= 100) check("letter_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Letters packed with n0 in the low nibble
  task automatic send_code(input logic [39:0] code, input int len,
                           input int n_send);
    for (int i = 0; i < n_send; i++) begin
      logic [3:0] nib;
      nib = code[4*i +: 4];
      send_letter(nib, (i == len - 1));
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  localparam logic [39:0] SXIOPO   = 40'h00_0091_95AD; // D A 5 9 1 9
  localparam logic [39:0] PPPPPPPN = 40'h00_F111_1111;
  localparam logic [39:0] SEVEN    = 40'h00_0111_1111;
  localparam logic [39:0] NINE     = 40'h01_1111_1111;

  initial begin
    int cyc;
    int busy_cnt;
    rst      = 1'b1;
    in_nib   = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_we", {31'd0, wr_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_slots_used", {25'd0, slots_used}, 32'd0);
    check("rst_wr_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);

    // Reset-exit clear: 8 enable-byte writes of 0x00, busy for 8 cycles
    push_clear();
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (in_ready) break;
    end
    check("clear_busy_cycles", busy_cnt, 32'd8);
    check("clear_in_ready", {31'd0, in_ready}, 32'd1);

    // SXIOPO into slot 0, with latency checks
    push_slot(0, 8'hD9, 8'h91, 8'hAD, 8'hAD);
    send_code(SXIOPO, 6, 6);
    @(negedge clk);
    check("latency_byte0_we", {31'd0, wr_we}, 32'd1);
    wait_ready(cyc);
    check("latency_ready", cyc, 32'd4);
    check("slots_after_1", {25'd0, slots_used}, 32'd1);

    // 8-letter PPPPPPPN into slot 1
    push_slot(1, 8'h11, 8'h91, 8'h71, 8'h19);
    send_code(PPPPPPPN, 8, 8);
    @(negedge clk);
    wait_ready(cyc);
    check("slots_after_2", {25'd0, slots_used}, 32'd2);

    // Bad lengths: 7 and 9 letters
    exp_err.push_back(2'd1);
    send_code(SEVEN, 7, 7);
    exp_err.push_back(2'd1);
    send_code(NINE, 9, 9);
    repeat (3) @(negedge clk);
    check("slots_after_badlen", {25'd0, slots_used}, 32'd2);

    // Fill slots 2..7, then one more is rejected as full
    for (int s = 2; s < 8; s++) begin
      push_slot(s, 8'hD9, 8'h91, 8'hAD, 8'hAD);
      send_code(SXIOPO, 6, 6);
      @(negedge clk);
      wait_ready(cyc);
    end
    check("full_flag", {31'd0, full}, 32'd1);
    check("slots_full", {25'd0, slots_used}, 32'd8);
    exp_err.push_back(2'd2);
    send_code(SXIOPO, 6, 6);
    repeat (3) @(negedge clk);
    check("slots_after_fullerr", {25'd0, slots_used}, 32'd8);

    // clr in COLLECT empties the table
    push_clear();
    pulse_clr();
    wait_ready(cyc);
    check("slots_after_clr", {25'd0, slots_used}, 32'd0);
    check("full_after_clr", {31'd0, full}, 32'd0);

    // clr during byte2 write: slot completes, then clear runs
    push_slot(0, 8'hD9, 8'h91, 8'hAD, 8'hAD);
    push_clear();
    send_code(SXIOPO, 6, 6);
    @(negedge clk);            // byte0 cycle
    @(negedge clk);            // byte2 cycle
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_ready(cyc);
    check("slots_after_midwrite_clr", {25'd0, slots_used}, 32'd0);

    // clr after 3 letters drops the partial code
    send_code(SXIOPO, 6, 3);
    push_clear();
    pulse_clr();
    wait_ready(cyc);
    push_slot(0, 8'hD9, 8'h91, 8'hAD, 8'hAD);
    send_code(SXIOPO, 6, 6);
    @(negedge clk);
    wait_ready(cyc);
    check("slots_after_partial_drop", {25'd0, slots_used}, 32'd1);

    repeat (5) @(negedge clk);
    check("exp_wr_drained", exp_wr.size(), 32'd0);
    check("exp_err_drained", exp_err.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
